// File: rtl/updown_counter_param_if.sv
// Command/status bundle for updown_counter_param.
// The master side issues count commands; the slave side is the counter itself.
interface updown_counter_param_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up_down;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, up_down, clr, load, load_val,
    input  count, tc, wrap, load_err
  );

  modport slave (
    input  en, up_down, clr, load, load_val,
    output count, tc, wrap, load_err
  );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter over 0..MODULUS-1 with optional saturation,
// synchronous clear, parallel load, terminal-count and wrap/load-error pulses.
// Command priority on each edge: clr > load > en > hold.
module updown_counter_param #(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  updown_counter_param_if.slave bus
);

  if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_param
    $error("updown_counter_param: illegal WIDTH/MODULUS combination");
  end

  // Largest reachable count; all range-end decisions compare against this,
  // so arithmetic stays modulo MODULUS rather than modulo 2**WIDTH.
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             lerr_q, lerr_d;
  logic             at_top, at_bot;

  // Range-end step: wraps to the opposite end or holds, depending on SATURATE.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] c);
    if (c == MAX_C) return SATURATE ? c : '0;
    return c + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] c);
    if (c == '0) return SATURATE ? c : MAX_C;
    return c - WIDTH'(1);
  endfunction

  assign at_top = (count_q == MAX_C);
  assign at_bot = (count_q == '0);

  // Next-state selection in priority order; flags are one-cycle pulses.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    lerr_d  = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      if (bus.load_val <= MAX_C) begin
        count_d = bus.load_val;
      end else begin
        count_d = MAX_C;
        lerr_d  = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up_down) begin
        count_d = step_up(count_q);
        wrap_d  = at_top;
      end else begin
        count_d = step_down(count_q);
        wrap_d  = at_bot;
      end
    end
  end

  // State register; async reset clears count and both pulses at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      lerr_q  <= lerr_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = lerr_q;
  assign bus.tc       = bus.en & ~bus.clr & ~bus.load &
                        ((bus.up_down & at_top) | (~bus.up_down & at_bot));

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three instances (default, MODULUS=6 wrapping,
// MODULUS=6 saturating) driven by directed vectors with a queued scoreboard.
module tb_updown_counter_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  updown_counter_param_if #(.WIDTH(3)) if0 ();
  updown_counter_param_if #(.WIDTH(3)) if1 ();
  updown_counter_param_if #(.WIDTH(3)) if2 ();

  updown_counter_param #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  updown_counter_param #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  updown_counter_param #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2));

  typedef struct {
    int         dut;
    bit         tc;
    logic [2:0] cnt;
    bit         wrap;
    bit         lerr;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    if0.en = 0; if0.up_down = 0; if0.clr = 0; if0.load = 0; if0.load_val = '0;
    if1.en = 0; if1.up_down = 0; if1.clr = 0; if1.load = 0; if1.load_val = '0;
    if2.en = 0; if2.up_down = 0; if2.clr = 0; if2.load = 0; if2.load_val = '0;
  endtask

  task automatic drive(input int d, input bit en, input bit ud, input bit clr,
                       input bit ld, input logic [2:0] lv);
    case (d)
      0: begin if0.en = en; if0.up_down = ud; if0.clr = clr; if0.load = ld; if0.load_val = lv; end
      1: begin if1.en = en; if1.up_down = ud; if1.clr = clr; if1.load = ld; if1.load_val = lv; end
      default: begin if2.en = en; if2.up_down = ud; if2.clr = clr; if2.load = ld; if2.load_val = lv; end
    endcase
  endtask

  // One command cycle on instance d, with the tc expected during the cycle and
  // the count/wrap/load_err expected after the edge.
  task automatic step(input int d, input bit en, input bit ud, input bit clr, input bit ld,
                      input logic [2:0] lv, input bit etc, input logic [2:0] ecnt,
                      input bit ew, input bit el, input string nm);
    exp_t e;
    @(negedge clk);
    set_idle();
    drive(d, en, ud, clr, ld, lv);
    e.dut = d; e.tc = etc; e.cnt = ecnt; e.wrap = ew; e.lerr = el; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic sample(input int d, output bit t, output logic [2:0] c,
                        output bit w, output bit l);
    case (d)
      0:       begin t = if0.tc; c = if0.count; w = if0.wrap; l = if0.load_err; end
      1:       begin t = if1.tc; c = if1.count; w = if1.wrap; l = if1.load_err; end
      default: begin t = if2.tc; c = if2.count; w = if2.wrap; l = if2.load_err; end
    endcase
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    cmp("drain_timeout", sb.size(), 0);
  endtask

  // Monitor: tc is sampled just before the edge, registered outputs just after.
  initial begin
    exp_t e;
    bit t, w, l;
    logic [2:0] c;
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        sample(e.dut, t, c, w, l);
        cmp({e.nm, ".tc"}, t, e.tc);
        @(posedge clk);
        #1;
        sample(e.dut, t, c, w, l);
        cmp({e.nm, ".count"}, c, e.cnt);
        cmp({e.nm, ".wrap"}, w, e.wrap);
        cmp({e.nm, ".load_err"}, l, e.lerr);
      end
    end
  end

  logic [2:0] t1c[9]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
  bit         t1tc[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
  logic [2:0] t2c[7]  = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};
  bit         t2tc[7] = '{1, 0, 0, 0, 0, 0, 1};

  initial begin
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst.count0", if0.count, 0);
    cmp("rst.wrap0", if0.wrap, 0);
    cmp("rst.lerr0", if0.load_err, 0);
    cmp("rst.count1", if1.count, 0);
    cmp("rst.count2", if2.count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default instance counting up through the wrap.
    for (int i = 0; i < 9; i++)
      step(0, 1, 1, 0, 0, 3'd0, t1tc[i], t1c[i], t1tc[i], 0, $sformatf("t1_%0d", i));

    // MODULUS=6 counting down from 0.
    for (int i = 0; i < 7; i++)
      step(1, 1, 0, 0, 0, 3'd0, t2tc[i], t2c[i], t2tc[i], 0, $sformatf("t2_%0d", i));

    // Saturating instance: load 4, up into the top end, clear, down at the bottom.
    step(2, 0, 0, 0, 1, 3'd4, 0, 3'd4, 0, 0, "t3_load");
    step(2, 1, 1, 0, 0, 3'd0, 0, 3'd5, 0, 0, "t3_up0");
    step(2, 1, 1, 0, 0, 3'd0, 1, 3'd5, 1, 0, "t3_up1");
    step(2, 1, 1, 0, 0, 3'd0, 1, 3'd5, 1, 0, "t3_up2");
    step(2, 1, 1, 0, 0, 3'd0, 1, 3'd5, 1, 0, "t3_up3");
    step(2, 0, 0, 1, 0, 3'd0, 0, 3'd0, 0, 0, "t3_clr");
    step(2, 1, 0, 0, 0, 3'd0, 1, 3'd0, 1, 0, "t3_dn0");
    step(2, 1, 0, 0, 0, 3'd0, 1, 3'd0, 1, 0, "t3_dn1");

    // Load beats enable; out-of-range load clamps and pulses load_err once.
    step(0, 1, 1, 0, 1, 3'd3, 0, 3'd3, 0, 0, "t4_load3");
    step(1, 1, 1, 0, 1, 3'd7, 0, 3'd5, 0, 1, "t4_load7");
    step(1, 0, 0, 0, 0, 3'd0, 0, 3'd5, 0, 0, "t4_after");

    // Clear beats load and enable; load also masks tc at the top end.
    step(0, 0, 0, 0, 1, 3'd4, 0, 3'd4, 0, 0, "t5_load4");
    step(0, 1, 1, 1, 1, 3'd6, 0, 3'd0, 0, 0, "t5_clr");
    step(0, 0, 0, 0, 1, 3'd7, 0, 3'd7, 0, 0, "t5_load7");
    step(0, 1, 1, 0, 1, 3'd2, 0, 3'd2, 0, 0, "t5_loadtop");
    step(0, 1, 1, 0, 0, 3'd0, 0, 3'd3, 0, 0, "t5_up");

    // Asynchronous reset while counting up at 5.
    step(0, 1, 1, 0, 0, 3'd0, 0, 3'd4, 0, 0, "t6_up0");
    step(0, 1, 1, 0, 0, 3'd0, 0, 3'd5, 0, 0, "t6_up1");
    drain();
    @(negedge clk);
    set_idle();
    drive(0, 1, 1, 0, 0, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("t6_async.count", if0.count, 0);
    cmp("t6_async.wrap", if0.wrap, 0);
    @(posedge clk);
    #1;
    cmp("t6_held.count", if0.count, 0);
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;
    step(0, 1, 1, 0, 0, 3'd0, 0, 3'd1, 0, 0, "t6_rel0");
    step(0, 1, 1, 0, 0, 3'd0, 0, 3'd2, 0, 0, "t6_rel1");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
